io_uart_tx: RTL and testbench
=============================

Name: io_uart_tx

Overview:
- Output-port peripheral that sits at the far end of the CPU's output-register interface and feeds status back to the CPU's input-port interface.
- Accepts byte writes strobed by the CPU's port write enable and buffers them in a small FIFO.
- Serialises each byte as an 8N1 asynchronous frame on `tx`.
- Exposes an 8-bit status byte that connects directly to one of the CPU's 8-bit input ports, so software can poll it.

Parameters:
- DEPTH, 4, FIFO entries. Legal values: 2 or 4.
- CLKS_PER_BIT, 16, clk cycles per serial bit. Must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  single-cycle write strobe from the CPU output-port decode.
- wr_data  input  8  byte to send; valid when wr_en=1.
- ovf_clr  input  1  single-cycle pulse that clears the sticky overflow flag.
- tx  output  1  serial line; idles high.
- status  output  8  status byte for a CPU input port:
  - [0] busy
  - [1] full
  - [2] empty
  - [3] overflow
  - [6:4] count
  - [7] always 0
- busy  output  1  transmitter not idle; same as status[0].

Behaviour:
- One clock domain. All state updates on the rising edge of clk. Reset is synchronous and active-high.
- Reset values:
  - tx=1
  - FIFO empty, count=0
  - FSM in IDLE
  - overflow=0
  - status=8'h04 (empty=1, all other bits 0)
  - busy=0
  - Baud and bit counters = 0
  - Reset asserted mid-frame aborts the frame; tx=1 from the next edge. Any FIFO contents are discarded.
- FIFO:
  - Circular buffer with write and read pointers that wrap modulo DEPTH. count ranges 0..DEPTH.
  - Push: wr_en=1 and (not full, or a pop occurs in the same cycle). Data is stored at the edge where wr_en is sampled.
  - wr_en=1 while full with no same-cycle pop: byte dropped, FIFO unchanged, overflow set to 1 at that edge.
  - overflow is sticky until ovf_clr or reset. If ovf_clr and a new overflow event occur in the same cycle, set wins (overflow=1).
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP. tx is a registered output.
  - IDLE: tx=1.
    - If FIFO not empty (registered count>0): pop the head into the shift register, go to START, drive tx=0 from that edge.
    - A write into an empty idle FIFO at edge N therefore gives tx falling at edge N+1.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: each bit is held CLKS_PER_BIT cycles, sent LSB first. After bit 7, go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. On its last cycle:
    - FIFO not empty: pop and go directly to START (no idle gap between frames).
    - FIFO empty: go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- The baud counter counts 0..CLKS_PER_BIT-1 and reloads 0 on every bit boundary and every state entry.
- busy=1 in START, DATA and STOP; busy=0 in IDLE.
- status is combinational from registered state and reflects post-edge values; no added latency.
- full = (count==DEPTH); empty = (count==0).

Test Plan:
All scenarios use DEPTH=4 and CLKS_PER_BIT=4.
- Reset, then write 8'hA5 at edge N:
  - tx=0 over edges N+1..N+4.
  - Then tx = 1,0,1,0,0,1,0,1, each held 4 cycles.
  - Then stop bit 1 for 4 cycles. busy falls at edge N+41.
  - Expected status:
    - status=8'h05 at N+1, after the pop (busy=1, empty=1, count=0).
    - status=8'h04 after N+41.
- Write 8'h01, 8'h02, 8'h03 on consecutive cycles:
  - Three frames back to back, 120 cycles, with no idle-high gap beyond the stop bits.
  - Decoded bytes are 01, 02, 03 in order.
- Six writes on consecutive cycles while idle:
  - First byte popped; 4 buffered; count=4, full=1.
  - Sixth write dropped; overflow=1.
  - Decoded output is bytes 1..5 only.
  - ovf_clr pulse gives overflow=0.
- FIFO full during the STOP last cycle, with wr_en asserted in that same cycle:
  - Write accepted, count stays 4, overflow stays 0.
- Assert reset for one cycle mid-DATA after 3 bits:
  - tx=1 at the next edge, status=8'h04.
  - No further frame starts without a new write.
- ovf_clr and an overflowing write in the same cycle: overflow=1 afterwards.

Source files
------------

// File: rtl/io_uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO, with a status byte that software
// can poll through a CPU input port.
module io_uart_tx #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       ovf_clr,
  output logic       tx,
  output logic [7:0] status,
  output logic       busy
);

  localparam int              PW         = (DEPTH > 2) ? 2 : 1;
  localparam int              BW         = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      COUNT_FULL = 3'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [2:0]    r_count;
  logic          r_ovf;
  logic [1:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic w_empty;
  logic w_full;
  logic w_baud_last;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty     = (r_count == 3'd0);
  assign w_full      = (r_count == COUNT_FULL);
  assign w_baud_last = (r_baud == BAUD_LAST);

  // The head is taken either from IDLE or on the final cycle of a stop bit.
  assign w_pop  = !w_empty && ((r_state == ST_IDLE) ||
                               (r_state == ST_STOP && w_baud_last));
  assign w_push = wr_en && (!w_full || w_pop);
  assign w_drop = wr_en && w_full && !w_pop;

  // NOTE: sequential state always uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; the pointers and
  // count define which entries are valid, so clearing the data buys nothing.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_baud <= w_baud_last ? '0 : r_baud + 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_baud <= '0;
          if (!w_empty) begin
            r_shift <= r_mem[r_rd_ptr];
            r_state <= ST_START;
            r_tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (w_baud_last) begin
            r_state   <= ST_DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
          end
        end
        ST_DATA: begin
          if (w_baud_last) begin
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end
        end
        ST_STOP: begin
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (w_baud_last) begin
            if (!w_empty) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= ST_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_tx    <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx     = r_tx;
  assign busy   = (r_state != ST_IDLE);
  assign status = {1'b0, r_count, r_ovf, w_empty, w_full, busy};

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: a serial monitor decodes frames and compares them
// against bytes queued by the stimulus, alongside cycle-exact status/tx checks.
module tb_io_uart_tx;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ovf_clr;
  logic       tx;
  logic [7:0] status;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb [$];
  logic [7:0] rx_byte;
  logic       rx_abort;
  logic [7:0] rx_exp;

  io_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .ovf_clr (ovf_clr),
    .tx      (tx),
    .status  (status),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (busy !== 1'b0 && n < max) begin
      tick();
      n++;
    end
  endtask

  // Serial monitor: sample each data bit in its second cycle, abort on reset.
  always begin
    @(negedge clk);
    if (reset === 1'b0 && tx === 1'b0) begin
      rx_abort = 1'b0;
      rx_byte  = 8'h00;
      for (int c = 1; c <= 10*CPB - 1; c++) begin
        @(negedge clk);
        if (reset !== 1'b0) begin
          rx_abort = 1'b1;
          break;
        end
        if (c == CPB/2) check("rx_start", tx, 1'b0);
        if (c >= CPB + 1 && c < 9*CPB && ((c - CPB - 1) % CPB) == 0)
          rx_byte[(c - CPB - 1) / CPB] = tx;
        if (c == 9*CPB + 1) check("rx_stop", tx, 1'b1);
      end
      if (!rx_abort) begin
        check("rx_frame_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          rx_exp = sb.pop_front();
          check("rx_byte", rx_byte, rx_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         lows;
    logic       exp_tx;
    logic [7:0] a5;

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    a5      = 8'hA5;
    repeat (3) tick();
    check("rst_status", status, 8'h04);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // Single frame, cycle-exact waveform.
    sb.push_back(8'hA5);
    write(8'hA5);
    check("t1_status_wr", status, 8'h10);
    tick();
    check("t1_status_pop", status, 8'h05);
    for (int c = 0; c < 10*CPB; c++) begin
      if (c < CPB)        exp_tx = 1'b0;
      else if (c < 9*CPB) exp_tx = a5[(c - CPB) / CPB];
      else                exp_tx = 1'b1;
      check("t1_tx", tx, exp_tx);
      check("t1_busy", busy, 1'b1);
      tick();
    end
    check("t1_busy_fall", busy, 1'b0);
    check("t1_status_end", status, 8'h04);

    // Three back-to-back frames.
    sb.push_back(8'h01);
    sb.push_back(8'h02);
    sb.push_back(8'h03);
    write(8'h01);
    write(8'h02);
    write(8'h03);
    check("t2_status", status, 8'h21);
    wait_idle(400, n);
    check("t2_len", n, 119);
    repeat (2) tick();
    check("t2_sb_drained", sb.size(), 0);

    // Six writes while idle: one popped, four buffered, sixth dropped.
    for (int i = 0; i < 5; i++) sb.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 6; i++) write(8'h10 + 8'(i));
    check("t3_status_ovf", status, 8'h4B);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_status_clr", status, 8'h43);
    // Write lands on the last stop-bit cycle of the first frame while full.
    repeat (34) tick();
    sb.push_back(8'h16);
    write(8'h16);
    check("t4_status_stopwr", status, 8'h43);
    check("t4_tx_start", tx, 1'b0);
    wait_idle(10*CPB*6 + 20, n);
    check("t3_drain_in_time", n < 10*CPB*6 + 20, 1'b1);
    repeat (2) tick();
    check("t3_sb_drained", sb.size(), 0);

    // ovf_clr coincident with an overflowing write: set wins.
    for (int i = 0; i < 5; i++) sb.push_back(8'h20 + 8'(i));
    for (int i = 0; i < 5; i++) write(8'h20 + 8'(i));
    check("t6_status_full", status, 8'h43);
    wr_en   = 1'b1;
    wr_data = 8'h25;
    ovf_clr = 1'b1;
    tick();
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    check("t6_ovf_set_wins", status, 8'h4B);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t6_ovf_cleared", status[3], 1'b0);
    wait_idle(10*CPB*6 + 20, n);
    check("t6_drain_in_time", n < 10*CPB*6 + 20, 1'b1);
    repeat (2) tick();
    check("t6_sb_drained", sb.size(), 0);

    // Reset mid-DATA after three bits aborts the frame.
    sb.push_back(8'h5A);
    write(8'h5A);
    repeat (17) tick();
    check("t5_mid_frame_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("t5_tx_after_rst", tx, 1'b1);
    check("t5_status_after_rst", status, 8'h04);
    lows = 0;
    repeat (60) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("t5_quiet", lows, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
